// File: rtl/sync_xfer_pkg.sv
// ---------------------------------------------------------------------------
// sync_xfer_pkg
//   Shared definitions for the sync_xfer_arb crossing-channel controller.
//   - xfer_state_e : handshake state encoding (IDLE/SETUP/REQ/REL)
//   - DEF_NUM_REQ / DEF_DATA_W : default requester count and payload width
//   - clog2 : constant function used to size the requester index
// ---------------------------------------------------------------------------
package sync_xfer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        REQ   = 2'd2,
        REL   = 2'd3
    } xfer_state_e;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_DATA_W  = 32;

    // Ceiling log2 for elaboration-time sizing; clog2(1) returns 0.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_xfer_rr_pick.sv
// ---------------------------------------------------------------------------
// sync_xfer_rr_pick
//   Combinational round-robin picker. Returns the first set request at or
//   above the pointer, scanning upward and wrapping at NUM_REQ.
//
//   Ports:
//     i_req_vld  in  NUM_REQ  request vector
//     i_ptr      in  ID_W     highest-priority index (always < NUM_REQ)
//     o_grant    out ID_W     winning index (0 when nothing is requested)
//     o_any      out 1        at least one request set
// ---------------------------------------------------------------------------
module sync_xfer_rr_pick
    import sync_xfer_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ID_W    = clog2(DEF_NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req_vld,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [ID_W-1:0]    o_grant,
    output logic               o_any
);

    always_comb begin
        int               w_idx;
        logic [ID_W-1:0]  w_sel;
        o_grant = '0;
        o_any   = |i_req_vld;
        w_idx   = 0;
        w_sel   = '0;
        // Walk offsets from the farthest to the nearest so the closest
        // requester at/after the pointer is the last (winning) assignment.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = int'(i_ptr) + k;
            if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
            w_sel = ID_W'(w_idx);
            if (i_req_vld[w_sel]) o_grant = w_sel;
        end
    end

endmodule

// File: rtl/sync_xfer_arb.sv
// ---------------------------------------------------------------------------
// sync_xfer_arb
//   Source-side controller sharing one 4-phase req/ack crossing channel
//   among NUM_REQ requesters. Arbitrates round-robin, launches the payload
//   one cycle ahead of the request bit, and sequences req/ack so the
//   multi-bit payload is stable whenever the destination samples it.
//
//   Optional build macro: SYNC_XFER_ARB_TIMEOUT_EN
//     defined   : saturating handshake-wait counter drives a sticky
//                 timeout_err flag (reporting only, no abort)
//     undefined : no counter, timeout_err tied 0
//
//   Ports:
//     nvdla_core_clk  in   1               clock
//     nvdla_core_rst  in   1               synchronous active-high reset
//     req_vld         in   NUM_REQ         per-requester request, held to done
//     req_data        in   NUM_REQ*DATA_W  payloads, requester i at [i*DATA_W +: DATA_W]
//     req_done        out  NUM_REQ         one-cycle completion pulse
//     xfer_req        out  1               registered request to the synchronizer
//     xfer_data       out  DATA_W          registered payload, stable across handshake
//     xfer_id         out  ID_W            registered granted index
//     xfer_ack_sync   in   1               synchronized destination acknowledge
//     busy            out  1               state != IDLE
//     timeout_err     out  1               sticky handshake timeout
// ---------------------------------------------------------------------------
module sync_xfer_arb
    import sync_xfer_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ID_W      = clog2(NUM_REQ),
    parameter int TIMEOUT_W = 10
) (
    input  logic                      nvdla_core_clk,
    input  logic                      nvdla_core_rst,
    input  logic [NUM_REQ-1:0]        req_vld,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_done,
    output logic                      xfer_req,
    output logic [DATA_W-1:0]         xfer_data,
    output logic [ID_W-1:0]           xfer_id,
    input  logic                      xfer_ack_sync,
    output logic                      busy,
    output logic                      timeout_err
);

    xfer_state_e          r_state;
    logic [ID_W-1:0]      r_ptr;
    logic                 r_xfer_req;
    logic [DATA_W-1:0]    r_xfer_data;
    logic [ID_W-1:0]      r_xfer_id;
    logic [NUM_REQ-1:0]   r_req_done;

    logic [ID_W-1:0]      w_grant;
    logic                 w_any;

    sync_xfer_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .i_req_vld (req_vld),
        .i_ptr     (r_ptr),
        .o_grant   (w_grant),
        .o_any     (w_any)
    );

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_xfer_req  <= 1'b0;
            r_xfer_data <= '0;
            r_xfer_id   <= '0;
            r_req_done  <= '0;
        end else begin
            r_req_done <= '0;
            unique case (r_state)
                IDLE: begin
                    // A still-high ack (e.g. left over from a reset taken
                    // mid-handshake) must drain before a new grant, or it
                    // would be mistaken for this transfer's acknowledge.
                    if (!xfer_ack_sync && w_any) begin
                        r_xfer_data <= req_data[int'(w_grant)*DATA_W +: DATA_W];
                        r_xfer_id   <= w_grant;
                        r_state     <= SETUP;
                    end
                end
                SETUP: begin
                    // Payload has been stable for one cycle before req rises.
                    r_xfer_req <= 1'b1;
                    r_state    <= REQ;
                end
                REQ: begin
                    if (xfer_ack_sync) begin
                        r_xfer_req <= 1'b0;
                        r_state    <= REL;
                    end
                end
                REL: begin
                    if (!xfer_ack_sync) begin
                        r_req_done[r_xfer_id] <= 1'b1;
                        if (r_xfer_id == ID_W'(NUM_REQ - 1)) r_ptr <= '0;
                        else                                 r_ptr <= r_xfer_id + 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_done  = r_req_done;
    assign xfer_req  = r_xfer_req;
    assign xfer_data = r_xfer_data;
    assign xfer_id   = r_xfer_id;
    assign busy      = (r_state != IDLE);

`ifdef SYNC_XFER_ARB_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] TMO_MAX = '1;

    logic [TIMEOUT_W-1:0] r_tmo_cnt;
    logic                 r_tmo_err;
    logic                 w_tmo_clr;
    logic                 w_tmo_run;

    // Clear on the cycles that enter REQ (from SETUP) and enter REL
    // (REQ seeing ack); otherwise count while waiting in REQ or REL.
    assign w_tmo_clr = (r_state == SETUP) || ((r_state == REQ) && xfer_ack_sync);
    assign w_tmo_run = (r_state == REQ) || (r_state == REL);

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            r_tmo_cnt <= '0;
            r_tmo_err <= 1'b0;
        end else if (w_tmo_clr) begin
            r_tmo_cnt <= '0;
        end else if (w_tmo_run && (r_tmo_cnt != TMO_MAX)) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
            // Flag on the same edge the counter lands on all-ones.
            if (r_tmo_cnt == TMO_MAX - 1'b1) r_tmo_err <= 1'b1;
        end
    end

    assign timeout_err = r_tmo_err;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_sync_xfer_arb.sv
module tb_sync_xfer_arb;
    localparam int NUM_REQ   = 4;
    localparam int DATA_W    = 32;
    localparam int ID_W      = 2;
    localparam int TIMEOUT_W = 4;

    logic                      nvdla_core_clk = 1'b0;
    logic                      nvdla_core_rst;
    logic [NUM_REQ-1:0]        req_vld;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_done;
    logic                      xfer_req;
    logic [DATA_W-1:0]         xfer_data;
    logic [ID_W-1:0]           xfer_id;
    logic                      xfer_ack_sync;
    logic                      busy;
    logic                      timeout_err;

    sync_xfer_arb #(
        .NUM_REQ   (NUM_REQ),
        .DATA_W    (DATA_W),
        .ID_W      (ID_W),
        .TIMEOUT_W (TIMEOUT_W)
    ) dut (
        .nvdla_core_clk (nvdla_core_clk),
        .nvdla_core_rst (nvdla_core_rst),
        .req_vld        (req_vld),
        .req_data       (req_data),
        .req_done       (req_done),
        .xfer_req       (xfer_req),
        .xfer_data      (xfer_data),
        .xfer_id        (xfer_id),
        .xfer_ack_sync  (xfer_ack_sync),
        .busy           (busy),
        .timeout_err    (timeout_err)
    );

    always #5 nvdla_core_clk = ~nvdla_core_clk;

    typedef struct {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
    } exp_t;

    typedef struct {
        bit                      rst;
        int                      lat;
        logic [NUM_REQ-1:0]      vld;
        int                      n;
        logic [4:0][ID_W-1:0]    ids;
    } vec_t;

    exp_t sb[$];
    int   checks   = 0;
    int   errors   = 0;
    int   done_cnt = 0;
    int   ack_lat  = 3;
    int   ack_mode = 0;   // 0: echo req after ack_lat, 1: stuck high, 2: stuck low
    logic [7:0] ack_hist = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge nvdla_core_clk);
        #3;
    endtask

    task automatic do_reset();
        nvdla_core_rst = 1'b1;
        tick();
        tick();
        nvdla_core_rst = 1'b0;
    endtask

    task automatic wait_done(input int target, input string name);
        int n;
        n = 0;
        while (done_cnt < target && n < 300) begin
            tick();
            n++;
        end
        checks++;
        if (done_cnt < target) begin
            errors++;
            $display("FAIL %s: done count %0d, required %0d (timed out)", name, done_cnt, target);
        end
    endtask

    task automatic wait_req(input string name);
        int n;
        n = 0;
        while (xfer_req !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk(name, xfer_req, 1);
    endtask

    function automatic logic [DATA_W-1:0] dval(input int row, input int i);
        return 32'hC0DE_0000 | DATA_W'(row << 8) | DATA_W'(i);
    endfunction

    // Destination model: the synchronized ack follows xfer_req ack_lat cycles later.
    initial begin
        xfer_ack_sync = 1'b0;
        forever begin
            @(posedge nvdla_core_clk);
            #1;
            ack_hist = {ack_hist[6:0], xfer_req};
            if (ack_mode == 1)      xfer_ack_sync = 1'b1;
            else if (ack_mode == 2) xfer_ack_sync = 1'b0;
            else                    xfer_ack_sync = ack_hist[ack_lat-1];
        end
    end

    // Scoreboard consumer: every req_done pulse must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge nvdla_core_clk);
            #2;
            if (req_done !== '0) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: req_done=%b with nothing expected", req_done);
                end else begin
                    e = sb.pop_front();
                    chk("done_onehot", 64'($onehot(req_done)), 1);
                    chk("done_bit", req_done[e.id], 1);
                    chk("done_xfer_id", xfer_id, e.id);
                    chk("done_xfer_data", xfer_data, e.data);
                    chk("done_busy", busy, 0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[5];
        int   base;
        int   n;

        tbl[0] = '{rst: 1'b1, lat: 2, vld: 4'b1111, n: 5, ids: {2'd0, 2'd3, 2'd2, 2'd1, 2'd0}};
        tbl[1] = '{rst: 1'b0, lat: 1, vld: 4'b1010, n: 3, ids: {2'd0, 2'd0, 2'd1, 2'd3, 2'd1}};
        tbl[2] = '{rst: 1'b0, lat: 4, vld: 4'b0011, n: 2, ids: {2'd0, 2'd0, 2'd0, 2'd1, 2'd0}};
        tbl[3] = '{rst: 1'b0, lat: 2, vld: 4'b1000, n: 2, ids: {2'd0, 2'd0, 2'd0, 2'd3, 2'd3}};
        tbl[4] = '{rst: 1'b0, lat: 3, vld: 4'b0110, n: 3, ids: {2'd0, 2'd0, 2'd1, 2'd2, 2'd1}};

        nvdla_core_rst = 1'b1;
        req_vld  = '0;
        req_data = '0;

        // Reset state and single transfer: data/id launched a cycle before req.
        tick();
        tick();
        chk("rst_xfer_req", xfer_req, 0);
        chk("rst_xfer_data", xfer_data, 0);
        chk("rst_xfer_id", xfer_id, 0);
        chk("rst_req_done", req_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_timeout_err", timeout_err, 0);
        nvdla_core_rst = 1'b0;
        ack_lat = 3;
        req_data[0*DATA_W +: DATA_W] = 32'hDEAD_BEEF;
        sb.push_back('{id: 2'd0, data: 32'hDEAD_BEEF});
        base = done_cnt;
        req_vld = 4'b0001;
        tick();
        chk("t1_setup_busy", busy, 1);
        chk("t1_setup_data", xfer_data, 32'hDEAD_BEEF);
        chk("t1_setup_id", xfer_id, 0);
        chk("t1_setup_req_low", xfer_req, 0);
        tick();
        chk("t1_req_high", xfer_req, 1);
        wait_done(base + 1, "t1_done");
        req_vld = '0;
        // Pointer now 1: with requesters 0 and 1 both asking, 1 wins.
        req_data[1*DATA_W +: DATA_W] = 32'h1111_0001;
        sb.push_back('{id: 2'd1, data: 32'h1111_0001});
        base = done_cnt;
        req_vld = 4'b0011;
        wait_done(base + 1, "t1_ptr_done");
        req_vld = '0;
        tick();
        chk("t1_idle_after", busy, 0);

        // Stale ack across reset blocks granting until it drops.
        ack_mode = 1;
        req_data[2*DATA_W +: DATA_W] = 32'h2222_3333;
        req_vld = 4'b0100;
        sb.push_back('{id: 2'd2, data: 32'h2222_3333});
        do_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_blocked_busy", busy, 0);
            chk("t3_blocked_req", xfer_req, 0);
        end
        base = done_cnt;
        ack_mode = 0;
        ack_hist = '0;
        tick();
        chk("t3_still_idle", busy, 0);
        tick();
        chk("t3_grant_busy", busy, 1);
        chk("t3_grant_id", xfer_id, 2);
        chk("t3_grant_data", xfer_data, 32'h2222_3333);
        wait_done(base + 1, "t3_done");
        req_vld = '0;

        // Reset taken in REQ: drops req, no done, then the transfer reruns.
        ack_lat = 3;
        req_data[0*DATA_W +: DATA_W] = 32'h4444_0000;
        sb.push_back('{id: 2'd0, data: 32'h4444_0000});
        base = done_cnt;
        req_vld = 4'b0001;
        wait_req("t4_req_seen");
        tick();
        nvdla_core_rst = 1'b1;
        tick();
        chk("t4_rst_req", xfer_req, 0);
        chk("t4_rst_busy", busy, 0);
        chk("t4_rst_done", req_done, 0);
        nvdla_core_rst = 1'b0;
        chk("t4_no_early_done", done_cnt - base, 0);
        wait_done(base + 1, "t4_rerun_done");
        req_vld = '0;

        // Requester drops mid-handshake; payload must hold and done still pulses.
        req_data[1*DATA_W +: DATA_W] = 32'h5555_AAAA;
        sb.push_back('{id: 2'd1, data: 32'h5555_AAAA});
        base = done_cnt;
        req_vld = 4'b0010;
        wait_req("t5_req_seen");
        req_vld = '0;
        req_data[1*DATA_W +: DATA_W] = 32'hFFFF_0000;
        n = 0;
        while (done_cnt == base && n < 100) begin
            chk("t5_data_hold", xfer_data, 32'h5555_AAAA);
            tick();
            n++;
        end
        chk("t5_done_seen", done_cnt - base, 1);
        tick();
        chk("t5_idle_after", busy, 0);

        // Round-robin vectors; pointer carries over between rows.
        for (int r = 0; r < 5; r++) begin
            if (tbl[r].rst) begin
                do_reset();
                tick();
            end
            ack_lat = tbl[r].lat;
            for (int i = 0; i < NUM_REQ; i++) req_data[i*DATA_W +: DATA_W] = dval(r, i);
            for (int k = 0; k < tbl[r].n; k++)
                sb.push_back('{id: tbl[r].ids[k], data: dval(r, int'(tbl[r].ids[k]))});
            base = done_cnt;
            req_vld = tbl[r].vld;
            wait_done(base + tbl[r].n, $sformatf("row%0d_done", r));
            req_vld = '0;
        end
        tick();
        chk("rows_idle", busy, 0);

`ifdef SYNC_XFER_ARB_TIMEOUT_EN
        // Ack never returns: flag after 15 REQ cycles, sticky, req held.
        do_reset();
        tick();
        ack_mode = 2;
        req_vld = 4'b0001;
        wait_req("t6_req_seen");
        for (int k = 0; k <= 20; k++) begin
            if (k == 14) chk("t6_no_err_yet", timeout_err, 0);
            if (k == 15) chk("t6_err_set", timeout_err, 1);
            tick();
        end
        chk("t6_err_sticky", timeout_err, 1);
        chk("t6_req_held", xfer_req, 1);
        req_vld = '0;
        do_reset();
        chk("t6_err_cleared", timeout_err, 0);
        ack_mode = 0;
`endif

        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
